sdram_frame_reader: RTL and testbench
=====================================

Name: sdram_frame_reader

Overview:
Display-side read prefetcher. It sits between sdram_controller's read port and the TFT timing/pixel output stage. It issues sequential single-word reads for a linear frame buffer and buffers the returned 16-bit RGB565 words in a small FIFO. The TFT stage pops pixels one per request. Single clock domain, shared with the SDRAM controller.

Parameters:
HADDR_WIDTH, 22, host address width ({bank,row,col}); matches the controller.
FRAME_BASE, 0, word address of the first pixel of the frame.
FRAME_WORDS, 130560, pixels per frame (480x272); must be >= 2.
FIFO_DEPTH, 16, pixel FIFO entries; power of 2, >= 4.
FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
clk  in  1  system clock, same as sdram_controller.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  1 = prefetching allowed; 0 = stop issuing new reads.
frame_start  in  1  1-cycle pulse at vertical sync: restart at FRAME_BASE and flush the FIFO.
ctrl_busy  in  1  sdram_controller busy (init/read in progress).
rd_enable  out  1  read request to the controller.
rd_addr  out  HADDR_WIDTH  read address to the controller.
rd_ready  in  1  controller read-return strobe.
rd_data  in  16  controller read data; valid on the edge where rd_ready=1.
pix_req  in  1  TFT pops one pixel this cycle.
pix_data  out  16  pixel word at the FIFO head.
pix_valid  out  1  FIFO not empty.
underflow  out  1  sticky: pix_req was seen while the FIFO was empty.
fifo_level  out  FIFO_AW+1  current occupancy (debug).

Behaviour:
- Reset values: rd_enable=0, rd_addr=FRAME_BASE, pix_data=0, pix_valid=0, underflow=0, fifo_level=0, FSM=S_IDLE, word_cnt=0, inflight=0.
- rd_addr is a register. It changes only on the edge where rd_ready=1, or on frame_start. The controller re-latches the address on every cycle rd_enable is high, so rd_addr must be stable between returns.
- FSM states:
  - S_IDLE: wait for enable=1 and frame_start.
  - S_FETCH: rd_enable = (fifo_level + inflight) <= FIFO_DEPTH-2.
  - S_HOLD: FIFO nearly full; rd_enable=0.
- FSM transitions:
  - S_FETCH -> S_HOLD when the rd_enable condition is false.
  - S_HOLD -> S_FETCH when the condition is true again.
  - Any state -> S_IDLE when enable=0. The outstanding read is still absorbed.
- inflight: set on the first cycle rd_enable=1 with ctrl_busy=0, or on the edge following an rd_ready while rd_enable stays 1. Cleared on rd_ready. Never exceeds 1, since the controller serves one read at a time.
- Read return (rd_ready=1):
  - Push rd_data into the FIFO. A push into a full FIFO is a design error; assert it in simulation.
  - rd_addr <= rd_addr+1 and word_cnt <= word_cnt+1.
  - When word_cnt == FRAME_WORDS-1: rd_addr <= FRAME_BASE and word_cnt <= 0 (wrap).
- Pop: pix_req=1 with pix_valid=1 removes the head. pix_data is combinational from the head, so first-word fall-through with no added latency.
- Push latency: a pushed word is visible on pix_data/pix_valid the cycle after rd_ready.
- Simultaneous push and pop: fifo_level unchanged. Pop with push into an empty FIFO: the pop is an underflow and the pushed word is kept.
- pix_req while empty: underflow <= 1. It stays 1 until rst_n or frame_start.
- frame_start:
  - Flush the FIFO, set rd_addr=FRAME_BASE, word_cnt=0, clear underflow.
  - If a read is in flight, set a discard flag. The next rd_ready is dropped (no push, no address increment), then the flag clears.
  - frame_start has priority over a simultaneous rd_ready.
- Address arithmetic: modulo 2^HADDR_WIDTH. FRAME_BASE+FRAME_WORDS must not exceed 2^HADDR_WIDTH; check at elaboration.
- Reset asserted mid-read: everything returns to reset values immediately. The controller is reset by the same rst_n.

Decomposition:
- Package sdram_frame_pkg holds:
  - FSM state encodings S_IDLE/S_FETCH/S_HOLD.
  - Default frame geometry constants (H_ACTIVE=480, V_ACTIVE=272).
  - HADDR_WIDTH default.
- Sub-module pixel_fifo:
  - Synchronous FIFO, parameterised on width and depth.
  - Binary read/write pointers plus a level counter.
  - FWFT output.
  - full/empty flags.

Test Plan:
1. Reset, then enable=1 and a frame_start pulse; a controller model returns rd_ready 8 cycles after each request. Required: rd_addr = FRAME_BASE, FRAME_BASE+1, ...; the FIFO fills to FIFO_DEPTH-1 max; rd_enable drops at level 14 with inflight=1.
2. FRAME_WORDS=4, continuous pix_req once pix_valid=1. Required: addresses 0,1,2,3,0,1...; pix_data sequence matches the model memory; underflow stays 0.
3. frame_start while a read is in flight (address 5). Required: the returned word is discarded; the FIFO is empty next cycle; the next issued address is FRAME_BASE; underflow is cleared.
4. pix_req held high from reset with no returns. Required: underflow=1 on the first cycle; it stays set across later pushes; it clears only on frame_start.
5. Push and pop on the same cycle at level 3. Required: level stays 3; head advances; data order is preserved.
6. enable drops mid-fetch. Required: rd_enable=0 next cycle; the in-flight word is still pushed; no further requests; fifo_level drains to 0 with pops.

Source files
------------

// File: rtl/sdram_frame_pkg.sv
// Shared constants for the display-side SDRAM frame reader: FSM encodings,
// default panel geometry and the controller's host address width.
package sdram_frame_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam int H_ACTIVE            = 480;
    localparam int V_ACTIVE            = 272;
    localparam int FRAME_WORDS_DEFAULT = H_ACTIVE * V_ACTIVE;
    localparam int HADDR_WIDTH_DEFAULT = 22;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO with binary pointers and a level
// counter; the head word is presented combinationally (zero while empty).
module pixel_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty     = (level == '0);
    assign full      = (level == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; empty gating keeps stale words off head_data.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sdram_frame_reader.sv
// Prefetches a linear RGB565 frame buffer from the SDRAM controller one word at
// a time and serves pixels to the TFT stage from a small FWFT FIFO.
module sdram_frame_reader
    import sdram_frame_pkg::*;
#(
    parameter int HADDR_WIDTH = HADDR_WIDTH_DEFAULT,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AW     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   frame_start,
    input  logic                   ctrl_busy,
    output logic                   rd_enable,
    output logic [HADDR_WIDTH-1:0] rd_addr,
    input  logic                   rd_ready,
    input  logic [15:0]            rd_data,
    input  logic                   pix_req,
    output logic [15:0]            pix_data,
    output logic                   pix_valid,
    output logic                   underflow,
    output logic [FIFO_AW:0]       fifo_level
);

    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0]       LAST_WORD  = CNT_W'(FRAME_WORDS - 1);
    localparam logic [HADDR_WIDTH-1:0] BASE_ADDR  = HADDR_WIDTH'(FRAME_BASE);
    localparam logic [FIFO_AW+1:0]     HIGH_WATER = (FIFO_AW+2)'(FIFO_DEPTH - 2);

    if (longint'(FRAME_BASE) + longint'(FRAME_WORDS) > (longint'(1) << HADDR_WIDTH)) begin : g_bad_frame
        $error("sdram_frame_reader: frame does not fit in the host address space");
    end
    if ((1 << FIFO_AW) != FIFO_DEPTH || FIFO_DEPTH < 4 || FRAME_WORDS < 2) begin : g_bad_geom
        $error("sdram_frame_reader: illegal FIFO or frame geometry");
    end

    logic [1:0]           state;
    logic                 inflight;
    logic                 discard;
    logic [CNT_W-1:0]     word_cnt;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 issue;
    logic                 below_high;
    logic [FIFO_AW+1:0]   pending;

    // The word already requested counts as occupied so a return always has room.
    assign pending    = {1'b0, fifo_level} + {{(FIFO_AW+1){1'b0}}, inflight};
    assign below_high = (pending <= HIGH_WATER);
    assign rd_enable  = (state == S_FETCH) && below_high;
    assign issue      = rd_enable && !ctrl_busy;
    assign push       = rd_ready && !discard && !frame_start;
    assign pix_valid  = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (!enable) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (frame_start) state <= S_FETCH;
                S_FETCH: if (!below_high) state <= S_HOLD;
                S_HOLD:  if (below_high)  state <= S_FETCH;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            discard   <= 1'b0;
            underflow <= 1'b0;
            rd_addr   <= BASE_ADDR;
            word_cnt  <= '0;
        end else begin
            if (rd_ready)   inflight <= 1'b0;
            else if (issue) inflight <= 1'b1;

            // A read accepted on this very edge also returns stale data later.
            if (frame_start)   discard <= (inflight || issue) && !rd_ready;
            else if (rd_ready) discard <= 1'b0;

            if (frame_start)                 underflow <= 1'b0;
            else if (pix_req && fifo_empty)  underflow <= 1'b1;

            if (frame_start) begin
                rd_addr  <= BASE_ADDR;
                word_cnt <= '0;
            end else if (push) begin
                if (word_cnt == LAST_WORD) begin
                    rd_addr  <= BASE_ADDR;
                    word_cnt <= '0;
                end else begin
                    rd_addr  <= rd_addr + HADDR_WIDTH'(1);
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end
        end
    end

    pixel_fifo #(
        .DATA_W (16),
        .DEPTH  (FIFO_DEPTH),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (frame_start),
        .push      (push),
        .push_data (rd_data),
        .pop       (pix_req),
        .head_data (pix_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    full_push_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pix_req));

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader: a table of single-cycle vectors plus
// multi-cycle sequences against a fixed-latency controller model.
module tb_sdram_frame_reader;

    localparam int BASE  = 100;
    localparam int WORDS = 20;

    typedef struct {
        logic        fs, en, busy, rdy;
        logic [15:0] data;
        logic        req;
        logic        e_en;
        logic [21:0] e_addr;
        logic        e_pv;
        logic [15:0] e_pd;
        logic        e_uf;
        logic [4:0]  e_lvl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0, frame_start = 1'b0, pix_req = 1'b0;
    logic        use_model = 1'b0;
    logic        drv_busy = 1'b0, drv_ready = 1'b0;
    logic [15:0] drv_data = '0;
    logic        mdl_busy, mdl_ready;
    logic [15:0] mdl_data;
    logic        ctrl_busy, rd_ready, rd_enable, pix_valid, underflow;
    logic [15:0] rd_data, pix_data;
    logic [21:0] rd_addr;
    logic [4:0]  fifo_level;
    logic [21:0] lat_addr;
    int          cnt;
    int          lat = 8;
    logic [21:0] issued [$];
    int          tests = 0;
    int          fails = 0;

    assign ctrl_busy = use_model ? mdl_busy  : drv_busy;
    assign rd_ready  = use_model ? mdl_ready : drv_ready;
    assign rd_data   = use_model ? mdl_data  : drv_data;

    sdram_frame_reader #(
        .HADDR_WIDTH (22),
        .FRAME_BASE  (BASE),
        .FRAME_WORDS (WORDS),
        .FIFO_DEPTH  (16),
        .FIFO_AW     (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_start (frame_start),
        .ctrl_busy   (ctrl_busy),
        .rd_enable   (rd_enable),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .pix_req     (pix_req),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [21:0] a);
        return {a[7:0] ^ 8'h5A, a[7:0]};
    endfunction

    // Controller: busy from acceptance through the return cycle, rd_ready lat cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy  <= 1'b0;
            mdl_ready <= 1'b0;
            mdl_data  <= '0;
            lat_addr  <= '0;
            cnt       <= 0;
            issued.delete();
        end else if (use_model) begin
            if (mdl_ready) begin
                mdl_ready <= 1'b0;
                mdl_busy  <= 1'b0;
            end else if (mdl_busy) begin
                if (cnt <= 1) begin
                    mdl_ready <= 1'b1;
                    mdl_data  <= mem_word(lat_addr);
                end
                cnt <= cnt - 1;
            end else if (rd_enable) begin
                mdl_busy <= 1'b1;
                lat_addr <= rd_addr;
                cnt      <= lat;
                issued.push_back(rd_addr);
            end
        end
    end

    function automatic vec_t mk(input logic fs, en, busy, rdy, input logic [15:0] d,
                                input logic req, input logic e_en, input int e_addr,
                                input logic e_pv, input logic [15:0] e_pd,
                                input logic e_uf, input int e_lvl);
        vec_t v;
        v.fs = fs; v.en = en; v.busy = busy; v.rdy = rdy; v.data = d; v.req = req;
        v.e_en = e_en; v.e_addr = 22'(e_addr); v.e_pv = e_pv; v.e_pd = e_pd;
        v.e_uf = e_uf; v.e_lvl = 5'(e_lvl);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic model);
        rst_n = 1'b0; use_model = model; enable = 1'b0; frame_start = 1'b0;
        pix_req = 1'b0; drv_busy = 1'b0; drv_ready = 1'b0; drv_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int c = 0;
        while (issued.size() < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("request_%0d_issued", n), 32'(issued.size() >= n), 32'd1);
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!rd_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("rd_ready_seen", 32'(rd_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic drive_push(input logic [15:0] d, input logic req);
        drv_ready = 1'b1; drv_data = d; pix_req = req;
        @(negedge clk);
        drv_ready = 1'b0; pix_req = 1'b0;
    endtask

    initial begin
        vec_t vecs [$];
        int   max_lvl, drop_lvl, k, bad;
        logic prev_en, uf_seen;

        //            fs en bs rd data      rq  en addr pv pd        uf lvl
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0,  0, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 16'h1111, 0,  1, 101, 1, 16'h1111, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0,  1, 101, 1, 16'h1111, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 16'h2222, 0,  1, 102, 1, 16'h1111, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1,  1, 102, 1, 16'h2222, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 16'h3333, 1,  1, 103, 1, 16'h3333, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 1,  1, 103, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 1,  1, 103, 0, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 16'h4444, 0,  1, 104, 1, 16'h4444, 1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 16'h5555, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 16'h6666, 0,  1, 101, 1, 16'h6666, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0,  0, 101, 1, 16'h6666, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1,  0, 101, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0,  0, 101, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 16'h7777, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0,  1, 100, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 16'h8888, 0,  1, 101, 1, 16'h8888, 0, 1));

        do_reset(1'b0);
        check("reset_rd_enable", 32'(rd_enable), 32'd0);
        check("reset_rd_addr", 32'(rd_addr), 32'(BASE));
        check("reset_pix_valid", 32'(pix_valid), 32'd0);
        check("reset_pix_data", 32'(pix_data), 32'd0);
        check("reset_underflow", 32'(underflow), 32'd0);
        check("reset_fifo_level", 32'(fifo_level), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            frame_start = vecs[i].fs; enable = vecs[i].en; drv_busy = vecs[i].busy;
            drv_ready = vecs[i].rdy; drv_data = vecs[i].data; pix_req = vecs[i].req;
            @(negedge clk);
            tests++;
            if ({rd_enable, rd_addr, pix_valid, pix_data, underflow, fifo_level} !==
                {vecs[i].e_en, vecs[i].e_addr, vecs[i].e_pv, vecs[i].e_pd, vecs[i].e_uf, vecs[i].e_lvl}) begin
                fails++;
                $display("FAIL vec_%0d: actual en=%0d addr=%0d pv=%0d pd=%h uf=%0d lvl=%0d required en=%0d addr=%0d pv=%0d pd=%h uf=%0d lvl=%0d",
                         i, rd_enable, rd_addr, pix_valid, pix_data, underflow, fifo_level,
                         vecs[i].e_en, vecs[i].e_addr, vecs[i].e_pv, vecs[i].e_pd, vecs[i].e_uf, vecs[i].e_lvl);
            end
        end

        // Fill until the high-water mark stops requests, then drain in order.
        do_reset(1'b1); lat = 8; enable = 1'b1;
        pulse_frame_start();
        max_lvl = 0; drop_lvl = -1; prev_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (prev_en && !rd_enable && drop_lvl < 0) drop_lvl = int'(fifo_level);
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            prev_en = rd_enable;
            @(negedge clk);
        end
        check("fill_drop_level", 32'(drop_lvl), 32'd14);
        check("fill_max_level", 32'(max_lvl), 32'd15);
        check("fill_request_count", 32'(issued.size()), 32'd15);
        bad = 0;
        for (int i = 0; i < issued.size(); i++) if (issued[i] !== 22'(BASE + i)) bad++;
        check("fill_address_order", 32'(bad), 32'd0);
        check("fill_rd_enable_low", 32'(rd_enable), 32'd0);
        enable = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 0 || i == 14) check($sformatf("fill_pop_%0d", i), 32'(pix_data), 32'(mem_word(22'(BASE + i))));
            else if (pix_data !== mem_word(22'(BASE + i))) check($sformatf("fill_pop_%0d", i), 32'(pix_data), 32'(mem_word(22'(BASE + i))));
            pix_req = 1'b1;
            @(negedge clk);
        end
        pix_req = 1'b0;
        check("fill_drained_level", 32'(fifo_level), 32'd0);

        // Streaming across the frame wrap with pops only while valid.
        do_reset(1'b1); lat = 2; enable = 1'b1;
        pulse_frame_start();
        k = 0; bad = 0; uf_seen = 1'b0;
        for (int c = 0; c < 800 && k < 45; c++) begin
            if (pix_valid) begin
                if (pix_data !== mem_word(22'(BASE + k % WORDS))) bad++;
                k++;
                pix_req = 1'b1;
            end else begin
                pix_req = 1'b0;
            end
            if (underflow) uf_seen = 1'b1;
            @(negedge clk);
        end
        pix_req = 1'b0;
        check("wrap_words_received", 32'(k), 32'd45);
        check("wrap_data_order", 32'(bad), 32'd0);
        check("wrap_no_underflow", 32'(uf_seen), 32'd0);
        check("wrap_last_before_wrap", 32'(issued.size() > 20 ? issued[19] : 22'h3FFFFF), 32'(BASE + WORDS - 1));
        check("wrap_first_after_wrap", 32'(issued.size() > 20 ? issued[20] : 22'h3FFFFF), 32'(BASE));

        // frame_start while address BASE+5 is outstanding.
        do_reset(1'b1); lat = 8; enable = 1'b1; pix_req = 1'b1;
        pulse_frame_start();
        wait_log(6);
        pix_req = 1'b0;
        check("restart_inflight_addr", 32'(issued.size() >= 6 ? issued[5] : 22'h3FFFFF), 32'(BASE + 5));
        check("restart_underflow_before", 32'(underflow), 32'd1);
        pulse_frame_start();
        check("restart_underflow_cleared", 32'(underflow), 32'd0);
        check("restart_addr_rewound", 32'(rd_addr), 32'(BASE));
        wait_ready();
        check("restart_discard_level", 32'(fifo_level), 32'd0);
        check("restart_discard_valid", 32'(pix_valid), 32'd0);
        check("restart_discard_addr", 32'(rd_addr), 32'(BASE));
        wait_log(7);
        check("restart_next_addr", 32'(issued.size() >= 7 ? issued[6] : 22'h3FFFFF), 32'(BASE));
        wait_ready();
        check("restart_first_word", 32'(pix_data), 32'(mem_word(22'(BASE))));

        // Sticky underflow survives pushes, cleared only by frame_start.
        do_reset(1'b0); pix_req = 1'b1;
        @(negedge clk);
        check("sticky_set", 32'(underflow), 32'd1);
        pix_req = 1'b0;
        drive_push(16'hAAAA, 1'b0);
        drive_push(16'hBBBB, 1'b0);
        check("sticky_after_push", 32'(underflow), 32'd1);
        check("sticky_level", 32'(fifo_level), 32'd2);
        check("sticky_head", 32'(pix_data), 32'hAAAA);
        pulse_frame_start();
        check("sticky_cleared", 32'(underflow), 32'd0);
        check("sticky_flushed", 32'(fifo_level), 32'd0);

        // Push and pop together at level 3.
        do_reset(1'b0);
        drive_push(16'hA001, 1'b0);
        drive_push(16'hA002, 1'b0);
        drive_push(16'hA003, 1'b0);
        check("pushpop_level_before", 32'(fifo_level), 32'd3);
        drive_push(16'hA004, 1'b1);
        check("pushpop_level_after", 32'(fifo_level), 32'd3);
        check("pushpop_head_0", 32'(pix_data), 32'hA002);
        pix_req = 1'b1;
        @(negedge clk);
        check("pushpop_head_1", 32'(pix_data), 32'hA003);
        @(negedge clk);
        check("pushpop_head_2", 32'(pix_data), 32'hA004);
        @(negedge clk);
        pix_req = 1'b0;
        check("pushpop_empty", 32'(pix_valid), 32'd0);
        check("pushpop_no_underflow", 32'(underflow), 32'd0);

        // enable drops with a read outstanding.
        do_reset(1'b1); lat = 8; enable = 1'b1;
        pulse_frame_start();
        wait_log(3);
        enable = 1'b0;
        @(negedge clk);
        check("stop_rd_enable", 32'(rd_enable), 32'd0);
        check("stop_level_before", 32'(fifo_level), 32'd2);
        wait_ready();
        check("stop_inflight_pushed", 32'(fifo_level), 32'd3);
        repeat (20) @(negedge clk);
        check("stop_no_new_requests", 32'(issued.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stop_pop_%0d", i), 32'(pix_data), 32'(mem_word(22'(BASE + i))));
            pix_req = 1'b1;
            @(negedge clk);
        end
        pix_req = 1'b0;
        check("stop_drained", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
